// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if -- request/completion bus between two requesters
// (instruction fetch, data memory), the arbiter and one shared memory port.
//   Requester side : if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata
//   Completion side: if_done, dm_done, rdata, err, sel
//   Memory side    : mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata
// Modports: slave = arbiter view, master = requester/memory (environment) view.
interface mem_port_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             dm_req;
    logic             dm_we;
    logic [WIDTH-1:0] dm_addr;
    logic [WIDTH-1:0] dm_wdata;
    logic             if_done;
    logic             dm_done;
    logic [WIDTH-1:0] rdata;
    logic             err;
    logic             sel;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_done, dm_done, rdata, err, sel, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_done, dm_done, rdata, err, sel, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- arbitrates instruction-fetch and data-memory requests
// onto one shared memory port with an ack timeout.
// Ports: clk, rst_n (async, active-low), bus (mem_port_arbiter_if.slave).
// Parameters: WIDTH (bus width), TIMEOUT (max BUSY cycles awaiting mem_ack, 1-255).
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration on
// simultaneous requests; undefined gives fixed priority with data winning.
// All outputs are registered; the memory command is captured at grant time.
module mem_port_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic               if_done_q, if_done_d;
    logic               dm_done_q, dm_done_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_dm_c;
`ifdef ARB_ROUND_ROBIN_EN
    logic               last_grant_q, last_grant_d;
`endif

    // Winner selection: on a tie, round-robin favours whoever was not granted last.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_dm_c = bus.dm_req && (!bus.if_req || !last_grant_q);
`else
        grant_dm_c = bus.dm_req;
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A done cycle never grants: the finished requester still
                // shows req and must not be re-served, giving the idle gap.
                if ((bus.if_req || bus.dm_req) && !(if_done_q || dm_done_q)) begin
                    state_d     = BUSY;
                    sel_d       = grant_dm_c;
                    mem_req_d   = 1'b1;
                    mem_we_d    = grant_dm_c & bus.dm_we;
                    mem_addr_d  = grant_dm_c ? bus.dm_addr  : bus.if_addr;
                    mem_wdata_d = grant_dm_c ? bus.dm_wdata : '0;
                    cnt_d       = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_dm_c;
`endif
                end
            end
            BUSY: begin
                // Ack wins over a timeout landing in the same cycle.
                if (bus.mem_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if_done_d   = ~sel_q;
                    dm_done_d   = sel_q;
                    rdata_d     = bus.mem_ack ? bus.mem_rdata : '0;
                    err_d       = ~bus.mem_ack;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.sel       = sel_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- scoreboard bench for mem_port_arbiter.
// Expected transactions are queued when requests are driven; a monitor checks
// each grant and each completion against the queue head. A responder plays the
// memory and acks on a chosen BUSY cycle (0 = never).
module tb_mem_port_arbiter;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 15;

    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ack_at = 0;
    int          busy_cnt = 0;
    logic        ack_force = 1'b0;
    logic [31:0] rsp_data = '0;
    logic [31:0] last_rdata = '0;
    logic        prev_req = 1'b0;

    mem_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: ack on the chosen BUSY cycle, or forced regardless of state.
    always @(negedge clk) begin
        if (bus.mem_req) busy_cnt++;
        else             busy_cnt = 0;
        bus.mem_ack   = ack_force || (bus.mem_req && ack_at != 0 && busy_cnt == ack_at);
        bus.mem_rdata = rsp_data;
    end

    // Scoreboard monitor: grant on mem_req rising, completion on done.
    always @(negedge clk) begin
        if (bus.mem_req && !prev_req) begin
            check("grant_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("grant_sel",   32'(bus.sel),    32'(exp_q[0].sel));
                check("grant_we",    32'(bus.mem_we), 32'(exp_q[0].we));
                check("grant_addr",  bus.mem_addr,    exp_q[0].addr);
                check("grant_wdata", bus.mem_wdata,   exp_q[0].wdata);
            end
        end
        if (bus.if_done || bus.dm_done) begin
            check("one_done", 32'(bus.if_done & bus.dm_done), 32'd0);
            check("done_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_dm",   32'(bus.dm_done), 32'(e.sel));
                check("done_rdata", bus.rdata,       e.rdata);
                check("done_err",  32'(bus.err),     32'(e.err));
                check("done_mem_req_low", 32'(bus.mem_req), 32'd0);
            end
        end
        prev_req = bus.mem_req;
    end

    function automatic exp_t mk_exp(input logic is_dm, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input int ack, input logic [31:0] rsp);
        exp_t e;
        e.sel   = is_dm;
        e.we    = is_dm & we;
        e.addr  = addr;
        e.wdata = is_dm ? wdata : 32'd0;
        e.rdata = (ack == 0) ? 32'd0 : rsp;
        e.err   = (ack == 0);
        return e;
    endfunction

    task automatic drop_reqs();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
    endtask

    // One single-requester transaction; called at a negedge with the arbiter idle.
    task automatic do_txn(input logic is_dm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack, input logic [31:0] rsp,
                          input bit drop_early);
        exp_t e;
        int   nb;
        bit   seen;
        e = mk_exp(is_dm, we, addr, wdata, ack, rsp);
        exp_q.push_back(e);
        last_rdata = e.rdata;
        ack_at   = ack;
        rsp_data = rsp;
        if (is_dm) begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        @(negedge clk);
        check("latency_mem_req", 32'(bus.mem_req), 32'd1);
        if (drop_early) drop_reqs();
        nb = 1;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.if_done || bus.dm_done) begin
                seen = 1'b1;
                break;
            end
            if (bus.mem_req) nb++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(nb), (ack == 0) ? 32'(TIMEOUT) : 32'(ack));
        drop_reqs();
        @(negedge clk);
        check("done_single_pulse", 32'(bus.if_done | bus.dm_done), 32'd0);
        check("idle_mem_req_low", 32'(bus.mem_req), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : safety_timer
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   seen;
        exp_t e;
        logic is_dm;
        drop_reqs();
        bus.if_addr = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_sel",     32'(bus.sel),     32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_done",    32'(bus.if_done | bus.dm_done), 32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        check("rst_err",     32'(bus.err),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch, ack on third BUSY cycle.
        do_txn(1'b0, 1'b0, 32'h0040_0000, 32'h0, 3, 32'h8C08_0004, 1'b0);
        // Data write, immediate ack.
        do_txn(1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 1, 32'h1234_5678, 1'b0);

        // Both requesters held for four transactions from a fresh last-grant.
        apply_reset();
        ack_at = 1;
        rsp_data = 32'hA5A5_0001;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            is_dm = (k % 2 == 0);
`else
            is_dm = 1'b1;
`endif
            e = mk_exp(is_dm, 1'b0, is_dm ? 32'h1001_0040 : 32'h0040_0100, 32'h0000_BEEF, 1, rsp_data);
            exp_q.push_back(e);
        end
        bus.if_req = 1'b1; bus.if_addr = 32'h0040_0100;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h1001_0040; bus.dm_wdata = 32'h0000_BEEF;
        seen = 0;
        for (int i = 0; i < 100 && seen < 4; i++) begin
            @(negedge clk);
            if (bus.if_done || bus.dm_done) seen++;
        end
        check("both_dones", 32'(seen), 32'd4);
        drop_reqs();
        @(negedge clk);
        last_rdata = rsp_data;

        // Timeout with no ack, then ack landing on the final permitted cycle.
        do_txn(1'b1, 1'b0, 32'h1001_0008, 32'h0, 0, 32'h0, 1'b0);
        do_txn(1'b1, 1'b0, 32'h1001_000C, 32'h0, int'(TIMEOUT), 32'h5555_AAAA, 1'b0);

        // Stray ack while idle must be ignored.
        rsp_data  = 32'hFFFF_FFFF;
        ack_force = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ack_no_req",  32'(bus.mem_req), 32'd0);
            check("idle_ack_no_done", 32'(bus.if_done | bus.dm_done), 32'd0);
            check("idle_ack_rdata",   bus.rdata, last_rdata);
        end
        ack_force = 1'b0;
        @(negedge clk);

        // Requester drops req mid-transaction; completion still happens.
        do_txn(1'b0, 1'b0, 32'h0040_0200, 32'h0, 2, 32'h0BAD_F00D, 1'b1);

        // Reset during the second BUSY cycle drops the transaction.
        ack_at = 0;
        exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0040_0300, 32'h0, 0, 32'h0));
        bus.if_req = 1'b1; bus.if_addr = 32'h0040_0300;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req",  32'(bus.mem_req),  32'd0);
        check("midrst_addr",     bus.mem_addr,      32'd0);
        check("midrst_sel",      32'(bus.sel),      32'd0);
        check("midrst_we",       32'(bus.mem_we),   32'd0);
        check("midrst_wdata",    bus.mem_wdata,     32'd0);
        check("midrst_done",     32'(bus.if_done | bus.dm_done), 32'd0);
        check("midrst_rdata",    bus.rdata,         32'd0);
        check("midrst_err",      32'(bus.err),      32'd0);
        exp_q.delete();
        drop_reqs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 1'b0, 32'h0040_0400, 32'h0, 2, 32'hCAFE_0001, 1'b0);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width of every bus.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum BUSY cycles to wait for mem_ack, range 1-255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  input  1  instruction-fetch request, held until if_done.
REQ-006 SHALL have port if_addr  input  WIDTH  fetch address.
REQ-007 SHALL have port dm_req  input  1  data-memory request, held until dm_done.
REQ-008 SHALL have ports dm_we  input  1, dm_addr  input  WIDTH, dm_wdata  input  WIDTH; data write enable, address, write data.
REQ-009 SHALL have ports if_done, dm_done  output  1  one-cycle completion pulse per requester.
REQ-010 SHALL have port rdata  output  WIDTH  read data, valid in the done cycle.
REQ-011 SHALL have port err  output  1  timeout flag, valid in the done cycle.
REQ-012 SHALL have port sel  output  1  registered 32-bit 2:1 mux select; 0 = fetch, 1 = data.
REQ-013 SHALL have ports mem_req, mem_we  output  1, mem_addr, mem_wdata  output  WIDTH; shared memory port.
REQ-014 SHALL have ports mem_ack  input  1, mem_rdata  input  WIDTH; memory completion and read data.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY.
REQ-016 IDLE: on any of if_req/dm_req high, SHALL latch the winner into sel and enter BUSY next cycle; no request keeps IDLE.
REQ-017 BUSY: mem_req SHALL be 1; mem_addr/mem_wdata/mem_we SHALL be the sel-chosen requester's signals (mem_we = dm_we when sel=1, else 0).
REQ-018 Latency: mem_req SHALL assert exactly 1 cycle after the winning req is first seen in IDLE.
REQ-019 On mem_ack in BUSY: rdata <= mem_rdata, err <= 0, winner's done pulses 1 cycle, return to IDLE.
REQ-020 A BUSY cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT without mem_ack: done pulses, err <= 1, rdata <= 0, return to IDLE.
REQ-021 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (err = 0).
REQ-022 mem_ack in IDLE SHALL be ignored.
REQ-023 At most one done output SHALL be high in any cycle; mem_req SHALL be 0 in IDLE.
REQ-024 Back-to-back: after done, the FSM SHALL spend at least one IDLE cycle before the next mem_req.
REQ-025 Requester deasserting req in BUSY SHALL NOT abort the transaction.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, sel 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_done 0, dm_done 0, rdata 0, err 0, counter 0, last-grant 0 (fetch).
REQ-027 Reset mid-BUSY SHALL drop the transaction without a done pulse.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant SHALL go to the requester not granted last; single request always wins.
REQ-029 Without ARB_ROUND_ROBIN_EN: fixed priority, dm_req SHALL always win over if_req; last-grant register not required.

Verification
REQ-030 if_req=1, if_addr=0x00400000, mem_ack at 3rd BUSY cycle with mem_rdata=0x8C080004 -> sel=0, mem_req 1 cycle after req, if_done pulse, rdata=0x8C080004, err=0.
REQ-031 dm_req=1, dm_we=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF, immediate ack -> mem_we=1, mem_addr/mem_wdata match, dm_done single pulse.
REQ-032 Both req held for 4 transactions, immediate acks -> RR build grants D,F,D,F; fixed build grants D,D,D,D.
REQ-033 dm_req, no mem_ack, TIMEOUT=15 -> dm_done after 15 BUSY cycles, err=1, rdata=0, then IDLE.
REQ-034 rst_n low during BUSY cycle 2 -> all outputs 0 same cycle, no done pulse, new if_req after release served normally.
